// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the FIR tile tap sequencer.
//   FIR_CONT_TO_TILE : configuration pulse {valid, num, mode}
//   FIR_TAP_LOAD     : tap beat {valid, data{re, im}, count}
//   fir_seq_state_t  : sequencer state encoding
package fir_pkg;

  localparam int unsigned MAX_TAPS   = 64;
  localparam int unsigned CNT_W      = $clog2(MAX_TAPS);
  localparam int unsigned NUM_W      = CNT_W + 1;
  localparam int unsigned SETTLE_CYC = 4;
  localparam int unsigned FIR_TAP_W  = 32;
  localparam int unsigned MODE_W     = 2;
  localparam int unsigned HALF_TAPS  = MAX_TAPS / 2;
  localparam int unsigned HALF_W     = $clog2(HALF_TAPS);

  typedef struct packed {
    logic [FIR_TAP_W/2-1:0] re;
    logic [FIR_TAP_W/2-1:0] im;
  } fir_tap_data_t;

  typedef struct packed {
    logic              valid;
    logic [NUM_W-1:0]  num;
    logic [MODE_W-1:0] mode;
  } FIR_CONT_TO_TILE;

  typedef struct packed {
    logic             valid;
    fir_tap_data_t    data;
    logic [CNT_W-1:0] count;
  } FIR_TAP_LOAD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_SETTLE,
    ST_LOAD,
    ST_DONE
  } fir_seq_state_t;

  // Tap count accepted only in 1..MAX_TAPS.
  function automatic logic num_is_legal(input logic [NUM_W-1:0] n);
    return (n != '0) && (n <= NUM_W'(MAX_TAPS));
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// fir_tap_sequencer_if: command, tap stream and tile-side bundle.
//   master : upstream front end (drives cfg_*/tap_valid/tap_data)
//   slave  : the sequencer (drives readies, tile outputs and status)
//   FIR_TAP_SYMM_EN adds cfg_symm.
interface fir_tap_sequencer_if;
  import fir_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [NUM_W-1:0]  cfg_num;
  logic [MODE_W-1:0] cfg_mode;
`ifdef FIR_TAP_SYMM_EN
  logic              cfg_symm;
`endif
  logic              tap_valid;
  logic              tap_ready;
  fir_tap_data_t     tap_data;
  FIR_CONT_TO_TILE   cont_to_tile_out;
  FIR_TAP_LOAD       tap_out;
  logic              busy;
  logic              done;
  logic              err;

`ifdef FIR_TAP_SYMM_EN
  modport master (
    output cfg_valid, cfg_num, cfg_mode, cfg_symm, tap_valid, tap_data,
    input  cfg_ready, tap_ready, cont_to_tile_out, tap_out, busy, done, err
  );
  modport slave (
    input  cfg_valid, cfg_num, cfg_mode, cfg_symm, tap_valid, tap_data,
    output cfg_ready, tap_ready, cont_to_tile_out, tap_out, busy, done, err
  );
`else
  modport master (
    output cfg_valid, cfg_num, cfg_mode, tap_valid, tap_data,
    input  cfg_ready, tap_ready, cont_to_tile_out, tap_out, busy, done, err
  );
  modport slave (
    input  cfg_valid, cfg_num, cfg_mode, tap_valid, tap_data,
    output cfg_ready, tap_ready, cont_to_tile_out, tap_out, busy, done, err
  );
`endif

endinterface

// File: rtl/fir_tap_mirror_buf.sv
// fir_tap_mirror_buf: half-length tap store for symmetric loading.
// Exists only when FIR_TAP_SYMM_EN is defined.
//   clr/wr_en/wr_data : write pointer restarts on clr, advances per write
//   rd_addr/rd_data_c : asynchronous read at an explicit address
`ifdef FIR_TAP_SYMM_EN
module fir_tap_mirror_buf
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  fir_tap_data_t     wr_data,
  input  logic [HALF_W-1:0] rd_addr,
  output fir_tap_data_t     rd_data_c
);

  fir_tap_data_t     mem [HALF_TAPS];
  logic [HALF_W-1:0] wr_ptr;

  // Write pointer: restarts for every accepted command.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) wr_ptr <= '0;
    else if (wr_en)    wr_ptr <= wr_ptr + HALF_W'(1);
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data_c = mem[rd_addr];

endmodule
`endif

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: drives one config pulse, a settle gap, then one
// tap beat per tap with descending count into the FIR tile.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fir_tap_sequencer_if.slave (command, taps, tile outputs,
//                busy/done/err status)
// Optional FIR_TAP_SYMM_EN: symmetric loading, half the taps supplied and
// the rest replayed in reverse from fir_tap_mirror_buf.
module fir_tap_sequencer
  import fir_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  fir_tap_sequencer_if.slave bus
);

  fir_seq_state_t   state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             cfg_ready_q, tap_ready_q, tap_ready_d, busy_q, done_q;
  FIR_CONT_TO_TILE  cont_q, cont_d;
  FIR_TAP_LOAD      tap_q, tap_d;
  logic             tap_hs;
`ifdef FIR_TAP_SYMM_EN
  logic             symm_q, symm_d, mirror_q, mirror_d;
  logic             buf_clr, buf_wr;
  fir_tap_data_t    buf_rd;
`endif

  assign tap_hs = (state_q == ST_LOAD) && tap_ready_q && bus.tap_valid;

  // Next state, counters and next output values.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cont_d  = '0;
    tap_d   = '0;
`ifdef FIR_TAP_SYMM_EN
    symm_d   = symm_q;
    mirror_d = mirror_q;
    buf_clr  = 1'b0;
    buf_wr   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          if (num_is_legal(bus.cfg_num)) begin
            state_d     = ST_CFG;
            num_d       = bus.cfg_num;
            cont_d.valid = 1'b1;
            cont_d.num   = bus.cfg_num;
            cont_d.mode  = bus.cfg_mode;
`ifdef FIR_TAP_SYMM_EN
            symm_d  = bus.cfg_symm;
            buf_clr = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_CFG: begin
        state_d = ST_SETTLE;
        cnt_d   = CNT_W'(SETTLE_CYC - 1);
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_LOAD;
          cnt_d   = CNT_W'(num_q - NUM_W'(1));
`ifdef FIR_TAP_SYMM_EN
          mirror_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LOAD: begin
`ifdef FIR_TAP_SYMM_EN
        // Mirror beat at count c replays the stored tap of index c.
        if (mirror_q) begin
          tap_d.valid = 1'b1;
          tap_d.data  = buf_rd;
          tap_d.count = cnt_q;
        end else
`endif
        if (tap_hs) begin
          tap_d.valid = 1'b1;
          tap_d.data  = bus.tap_data;
          tap_d.count = cnt_q;
`ifdef FIR_TAP_SYMM_EN
          buf_wr = symm_q;
          // Last supplied tap carries count floor(num/2).
          if (symm_q && (cnt_q != '0) && (cnt_q == CNT_W'(num_q >> 1)))
            mirror_d = 1'b1;
`endif
        end
        if (tap_d.valid) begin
          if (cnt_q == '0) state_d = ST_DONE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    tap_ready_d = (state_d == ST_LOAD);
`ifdef FIR_TAP_SYMM_EN
    tap_ready_d = tap_ready_d && !mirror_d;
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      num_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      cfg_ready_q <= 1'b1;
      tap_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cont_q      <= '0;
      tap_q       <= '0;
`ifdef FIR_TAP_SYMM_EN
      symm_q      <= 1'b0;
      mirror_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      cfg_ready_q <= (state_d == ST_IDLE);
      tap_ready_q <= tap_ready_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      cont_q      <= cont_d;
      tap_q       <= tap_d;
`ifdef FIR_TAP_SYMM_EN
      symm_q      <= symm_d;
      mirror_q    <= mirror_d;
`endif
    end
  end

`ifdef FIR_TAP_SYMM_EN
  fir_tap_mirror_buf u_mirror_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (buf_clr),
    .wr_en     (buf_wr),
    .wr_data   (bus.tap_data),
    .rd_addr   (HALF_W'(cnt_q)),
    .rd_data_c (buf_rd)
  );
`endif

  assign bus.cfg_ready        = cfg_ready_q;
  assign bus.tap_ready        = tap_ready_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.err              = err_q;
  assign bus.cont_to_tile_out = cont_q;
  assign bus.tap_out          = tap_q;

endmodule
